// File: rtl/ebox_mbox_req.sv
// ebox_mbox_req: turns one EBOX memory cycle into the MBOX request handshake.
// A retry limit and a response timeout bound every cycle.
// Optional feature macro: EBOX_MBOX_PARITY_EN (odd parity on the cache data bus).
module ebox_mbox_req #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 15
) (
    input  logic        eboxClk,
    input  logic        eboxReset,
    input  logic        reqValid,
    input  logic        reqRead,
    input  logic        reqWrite,
    input  logic [22:0] reqVMA,
    input  logic [35:0] reqWData,
    output logic        reqBusy,
    output logic        respValid,
    output logic [35:0] respData,
    output logic        respErr,
    output logic        eboxReq,
    output logic [22:0] mboxVMA,
    output logic        mboxRead,
    output logic        mboxWrite,
    output logic [35:0] cacheDataWrite,
    input  logic        cshEBOXT0,
    input  logic        cshEBOXRetry,
    input  logic        mboxRespIn,
    input  logic [35:0] cacheDataRead,
    input  logic        nxmErr
`ifdef EBOX_MBOX_PARITY_EN
    ,
    input  logic        cacheParRead,
    output logic        cacheParWrite
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ERR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [RW-1:0] rty_q, rty_d, rty_inc;
    logic          err_q, err_d;
    logic          tmo_hit;
    logic          par_ok;

    logic          busy_q, busy_d;
    logic          rv_q, rv_d;
    logic          rerr_q, rerr_d;
    logic [35:0]   rdata_q, rdata_d;
    logic          ereq_q, ereq_d;
    logic [22:0]   vma_q, vma_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [35:0]   wdata_q, wdata_d;
`ifdef EBOX_MBOX_PARITY_EN
    logic          wpar_q, wpar_d;
`endif

    // Read-data acceptance: odd parity over data plus parity bit when enabled
`ifdef EBOX_MBOX_PARITY_EN
    assign par_ok = ^{cacheDataRead, cacheParRead};
`else
    assign par_ok = 1'b1;
`endif

    // Saturating counter increments; timeout fires once TIMEOUT cycles were spent in REQ/WAIT
    always_comb begin
        tmo_inc = (tmo_q == TW'(TIMEOUT))   ? tmo_q : tmo_q + TW'(1);
        rty_inc = (rty_q == RW'(MAX_RETRY)) ? rty_q : rty_q + RW'(1);
        tmo_hit = (tmo_inc == TW'(TIMEOUT));
    end

    // Next-state, counter, latch and registered-output computation
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rty_d   = rty_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        vma_d   = vma_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
`ifdef EBOX_MBOX_PARITY_EN
        wpar_d  = wpar_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    vma_d   = reqVMA;
                    rd_d    = reqRead;
                    wr_d    = reqWrite;
                    wdata_d = reqWData;
`ifdef EBOX_MBOX_PARITY_EN
                    wpar_d  = ~^reqWData;
`endif
                    tmo_d   = '0;
                    rty_d   = '0;
                    if (reqRead ^ reqWrite) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                tmo_d = tmo_inc;
                if (nxmErr) begin
                    state_d = S_ERR;
                end else if (cshEBOXRetry) begin
                    rty_d = rty_inc;
                    if ((rty_inc == RW'(MAX_RETRY)) || tmo_hit) begin
                        state_d = S_ERR;
                    end
                end else if (cshEBOXT0) begin
                    state_d = rd_q ? S_WAIT : S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_inc;
                if (nxmErr) begin
                    state_d = S_ERR;
                end else if (mboxRespIn) begin
                    rdata_d = cacheDataRead;
                    state_d = S_DONE;
                    if (!par_ok) begin
                        err_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                tmo_d   = '0;
                rty_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        rv_d   = (state_d == S_DONE);
        rerr_d = (state_d == S_DONE) && err_d;
        ereq_d = (state_d == S_REQ);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            rty_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
            ereq_q  <= 1'b0;
            vma_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
`ifdef EBOX_MBOX_PARITY_EN
            wpar_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
            ereq_q  <= ereq_d;
            vma_q   <= vma_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
`ifdef EBOX_MBOX_PARITY_EN
            wpar_q  <= wpar_d;
`endif
        end
    end

    assign reqBusy        = busy_q;
    assign respValid      = rv_q;
    assign respErr        = rerr_q;
    assign respData       = rdata_q;
    assign eboxReq        = ereq_q;
    assign mboxVMA        = vma_q;
    assign mboxRead       = rd_q;
    assign mboxWrite      = wr_q;
    assign cacheDataWrite = wdata_q;
`ifdef EBOX_MBOX_PARITY_EN
    assign cacheParWrite  = wpar_q;
`endif

endmodule
